// File: rtl/mem_access_monitor.sv
// mem_access_monitor: classifies data-memory requests against a set of address
// windows, keeps per-region / unmapped / violation counters and latches the
// first violating access (cause, address, PC) until cleared.
module mem_access_monitor #(
  parameter int unsigned NUM_REGIONS = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h0100_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LEN  = {32'd16, 32'd1024, 32'd1024},
  parameter logic [NUM_REGIONS*2-1:0]      REGION_PERM = {2'b11, 2'b11, 2'b00},
  parameter bit HALT_ON_VIOL = 1'b1,
  localparam int unsigned SEL_W = $clog2(NUM_REGIONS + 1),
  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              CLK_I,
  input  logic              RST_NI,
  input  logic              REQ_I,
  input  logic              WE_I,
  input  logic [ADDR_W-1:0] ADDR_I,
  input  logic [31:0]       PC_I,
  input  logic              CLR_I,
  input  logic [SEL_W-1:0]  CNT_SEL_I,
  output logic [CNT_W-1:0]  CNT_O,
  output logic              VIOL_O,
  output logic              VIOL_PULSE_O,
  output logic [1:0]        VIOL_CAUSE_O,
  output logic [ADDR_W-1:0] VIOL_ADDR_O,
  output logic [31:0]       VIOL_PC_O,
  output logic [CNT_W-1:0]  VIOL_CNT_O,
  output logic              HALT_O
);

  typedef enum logic [0:0] {ARMED = 1'b0, CAPTURED = 1'b1} state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_UNMAP = 2'b01;
  localparam logic [1:0] CAUSE_RD    = 2'b10;
  localparam logic [1:0] CAUSE_WR    = 2'b11;

  // Saturating increment shared by every counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : (v + CNT_W'(1));
  endfunction

  state_e            state_q, state_d, state_base_s;
  logic [CNT_W-1:0]  cnt_q [NUM_REGIONS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGIONS];
  logic [CNT_W-1:0]  unm_cnt_q, unm_cnt_d;
  logic [CNT_W-1:0]  viol_cnt_q, viol_cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       pc_q, pc_d;
  logic              pulse_q, pulse_d;
  logic              halt_q, halt_d;

  logic [NUM_REGIONS-1:0] region_hit_s;
  logic                   hit_s;
  logic [IDX_W-1:0]       hit_idx_s;
  logic [1:0]             hit_perm_s;
  logic [1:0]             req_cause_s;
  logic                   viol_s;
  logic [CNT_W-1:0]       cnt_mux_s;

  // Window compare; the upper bound is formed in ADDR_W+1 bits so a window
  // touching the top of the address space never wraps around to zero.
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] len_s;
    assign base_s = REGION_BASE[g*ADDR_W +: ADDR_W];
    assign len_s  = REGION_LEN[g*ADDR_W +: ADDR_W];
    assign region_hit_s[g] = (len_s != {ADDR_W{1'b0}}) &&
                             (ADDR_I >= base_s) &&
                             ({1'b0, ADDR_I} < ({1'b0, base_s} + {1'b0, len_s}));
  end

  // Priority select of the hit region: lowest index wins on overlap.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = {IDX_W{1'b0}};
    hit_perm_s = 2'b00;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (region_hit_s[i]) begin
        hit_s      = 1'b1;
        hit_idx_s  = IDX_W'(i);
        hit_perm_s = REGION_PERM[2*i +: 2];
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // Request classification into a violation cause (none when idle or legal).
  always_comb begin
    req_cause_s = CAUSE_NONE;
    if (!REQ_I) begin
      req_cause_s = CAUSE_NONE;
    end else if (!hit_s) begin
      req_cause_s = CAUSE_UNMAP;
    end else if (!hit_perm_s[WE_I]) begin
      req_cause_s = WE_I ? CAUSE_WR : CAUSE_RD;
    end else begin
      req_cause_s = CAUSE_NONE;
    end
    viol_s = (req_cause_s != CAUSE_NONE);
  end

  // Next state: optional clear first, then account for the current request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    unm_cnt_d  = unm_cnt_q;
    viol_cnt_d = viol_cnt_q;
    cause_d    = cause_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    pulse_d    = 1'b0;

    if (CLR_I) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end
      unm_cnt_d  = {CNT_W{1'b0}};
      viol_cnt_d = {CNT_W{1'b0}};
      cause_d    = CAUSE_NONE;
      addr_d     = {ADDR_W{1'b0}};
      pc_d       = 32'h0000_0000;
    end else begin
      pulse_d    = 1'b0;
    end
    state_base_s = CLR_I ? ARMED : state_q;
    state_d      = state_base_s;

    if (REQ_I) begin
      if (hit_s) begin
        cnt_d[hit_idx_s] = sat_inc(cnt_d[hit_idx_s]);
      end else begin
        unm_cnt_d = sat_inc(unm_cnt_d);
      end
      if (viol_s) begin
        viol_cnt_d = sat_inc(viol_cnt_d);
        pulse_d    = 1'b1;
      end else begin
        pulse_d    = 1'b0;
      end
    end else begin
      pulse_d = 1'b0;
    end

    case (state_base_s)
      ARMED: begin
        if (viol_s) begin
          state_d = CAPTURED;
          cause_d = req_cause_s;
          addr_d  = ADDR_I;
          pc_d    = PC_I;
        end else begin
          state_d = ARMED;
        end
      end
      CAPTURED: state_d = CAPTURED;
      default:  state_d = ARMED;
    endcase

    halt_d = HALT_ON_VIOL ? (state_d == CAPTURED) : 1'b0;
  end

  // State, counter and capture registers.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= ARMED;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      unm_cnt_q  <= {CNT_W{1'b0}};
      viol_cnt_q <= {CNT_W{1'b0}};
      cause_q    <= CAUSE_NONE;
      addr_q     <= {ADDR_W{1'b0}};
      pc_q       <= 32'h0000_0000;
      pulse_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      unm_cnt_q  <= unm_cnt_d;
      viol_cnt_q <= viol_cnt_d;
      cause_q    <= cause_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      pulse_q    <= pulse_d;
      halt_q     <= halt_d;
    end
  end

  // Counter read mux; select values beyond the unmapped slot read as zero.
  always_comb begin
    cnt_mux_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_REGIONS; i++) begin
      cnt_mux_s = (CNT_SEL_I == SEL_W'(i)) ? cnt_q[i] : cnt_mux_s;
    end
    cnt_mux_s = (CNT_SEL_I == SEL_W'(NUM_REGIONS)) ? unm_cnt_q : cnt_mux_s;
  end

  assign CNT_O        = cnt_mux_s;
  assign VIOL_O       = (state_q == CAPTURED);
  assign VIOL_PULSE_O = pulse_q;
  assign VIOL_CAUSE_O = cause_q;
  assign VIOL_ADDR_O  = addr_q;
  assign VIOL_PC_O    = pc_q;
  assign VIOL_CNT_O   = viol_cnt_q;
  assign HALT_O       = halt_q;

endmodule
